// File: rtl/seg7_pkg.sv
// Shared definitions for the 4-digit multiplexed 7-segment scanner:
// glyph patterns, scan state encoding and small digit helpers.
package seg7_pkg;

  // Segment order is {g,f,e,d,c,b,a}, active high.
  localparam logic [6:0] GLYPH_0     = 7'h3F;
  localparam logic [6:0] GLYPH_1     = 7'h06;
  localparam logic [6:0] GLYPH_2     = 7'h5B;
  localparam logic [6:0] GLYPH_3     = 7'h4F;
  localparam logic [6:0] GLYPH_4     = 7'h66;
  localparam logic [6:0] GLYPH_5     = 7'h6D;
  localparam logic [6:0] GLYPH_6     = 7'h7D;
  localparam logic [6:0] GLYPH_7     = 7'h07;
  localparam logic [6:0] GLYPH_8     = 7'h7F;
  localparam logic [6:0] GLYPH_9     = 7'h6F;
  localparam logic [6:0] GLYPH_DASH  = 7'h40;
  localparam logic [6:0] GLYPH_BLANK = 7'h00;

  localparam logic [3:0] AN_ALL_OFF  = 4'hF;

  // Scanner phases: BLANK is the all-anodes-off guard gap, SHOW lights one digit.
  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } scan_state_t;

  // Select nibble idx of a 4-digit BCD word (idx 0 = rightmost digit).
  function automatic logic [3:0] pick_digit(input logic [15:0] value,
                                            input logic [1:0]  idx);
    logic [3:0] d;
    case (idx)
      2'd0:    d = value[3:0];
      2'd1:    d = value[7:4];
      2'd2:    d = value[11:8];
      default: d = value[15:12];
    endcase
    return d;
  endfunction

  // Bit k set when digit k and every digit above it are zero, i.e. digit k
  // belongs to a leading-zero run. Digit 0 is never part of the run so a
  // zero value still shows a single "0". Invalid codes (10-15) are non-zero
  // and therefore naturally end the run.
  function automatic logic [3:0] lead_zero_mask(input logic [15:0] value);
    logic [3:0] m;
    m[3] = (value[15:12] == 4'd0);
    m[2] = m[3] && (value[11:8] == 4'd0);
    m[1] = m[2] && (value[7:4]  == 4'd0);
    m[0] = 1'b0;
    return m;
  endfunction

endpackage

// File: rtl/bcd7seg_rom.sv
// Combinational BCD digit to 7-segment glyph lookup. Codes 10-15 are not
// decimal digits and show a dash so a corrupted value is visible.
module bcd7seg_rom
  import seg7_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] glyph
);

  // Pure lookup: every input code maps to exactly one glyph.
  always_comb begin
    case (digit)
      4'd0:    glyph = GLYPH_0;
      4'd1:    glyph = GLYPH_1;
      4'd2:    glyph = GLYPH_2;
      4'd3:    glyph = GLYPH_3;
      4'd4:    glyph = GLYPH_4;
      4'd5:    glyph = GLYPH_5;
      4'd6:    glyph = GLYPH_6;
      4'd7:    glyph = GLYPH_7;
      4'd8:    glyph = GLYPH_8;
      4'd9:    glyph = GLYPH_9;
      default: glyph = GLYPH_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Four-digit multiplexed 7-segment scan controller.
// Each digit slot is a BLANK gap (anodes off, avoids ghosting) followed by a
// SHOW period; slots run 0,1,2,3. New values enter through a one-deep shadow
// register and are copied to the displayed register only at a frame
// boundary, so a frame never mixes old and new digits.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int CLK_DIV   = 1000,
  parameter int BLANK_CYC = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [15:0] wr_data,
  input  logic        lz_en,
  output logic [6:0]  seg,
  output logic [3:0]  an_n,
  output logic        frame_done
);

  localparam int CNT_MAX = (CLK_DIV > BLANK_CYC) ? CLK_DIV : BLANK_CYC;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);

  scan_state_t      state, nxt_state;
  logic [1:0]       idx, nxt_idx;
  logic [CNT_W-1:0] cnt, nxt_cnt;
  logic             frame_end;

  logic [15:0]      shadow;
  logic [15:0]      active;
  logic             pending;

  logic [3:0]       mux_digit;
  logic [6:0]       mux_glyph;
  logic [3:0]       lz_mask;
  logic             lit;
  logic [6:0]       nxt_seg;
  logic [3:0]       nxt_an_n;

  assign wr_ready = !pending;

  // Scan state, digit index and cycle counter.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_BLANK;
      idx   <= 2'd0;
      cnt   <= '0;
    end else begin
      state <= nxt_state;
      idx   <= nxt_idx;
      cnt   <= nxt_cnt;
    end
  end

  // Next-state logic plus the outputs that belong to the next state, so the
  // output registers change on the same edge as the state they describe.
  // NOTE: every signal gets a default before the case; a path that leaves a
  // combinational output unassigned would infer a latch.
  always_comb begin
    nxt_state = state;
    nxt_idx   = idx;
    nxt_cnt   = cnt + CNT_W'(1);
    frame_end = 1'b0;
    case (state)
      ST_BLANK: begin
        if (cnt == BLANK_LAST) begin
          nxt_state = ST_SHOW;
          nxt_cnt   = '0;
        end
      end
      ST_SHOW: begin
        if (cnt == SHOW_LAST) begin
          nxt_state = ST_BLANK;
          nxt_cnt   = '0;
          nxt_idx   = idx + 2'd1;
          frame_end = (idx == 2'd3);
        end
      end
      default: begin
        nxt_state = ST_BLANK;
        nxt_cnt   = '0;
      end
    endcase

    // The active register only changes on a SHOW(3)->BLANK(0) edge, so the
    // pre-edge value is already correct for any upcoming SHOW period.
    mux_digit = pick_digit(active, nxt_idx);
    lz_mask   = lead_zero_mask(active);
    lit       = (nxt_state == ST_SHOW) && !(lz_en && lz_mask[nxt_idx]);
    nxt_an_n  = lit ? ~(4'b0001 << nxt_idx) : AN_ALL_OFF;
    nxt_seg   = lit ? mux_glyph : GLYPH_BLANK;
  end

  bcd7seg_rom u_rom (
    .digit (mux_digit),
    .glyph (mux_glyph)
  );

  // Registered display drive and frame boundary pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg        <= GLYPH_BLANK;
      an_n       <= AN_ALL_OFF;
      frame_done <= 1'b0;
    end else begin
      seg        <= nxt_seg;
      an_n       <= nxt_an_n;
      frame_done <= frame_end;
    end
  end

  // Write handshake and frame-aligned transfer from shadow to active.
  // A write needs !pending and a transfer needs pending, so the two branches
  // are mutually exclusive by construction.
  // NOTE: shadow and active are small registers that must read as zero after
  // reset, so they are reset explicitly rather than treated as uninitialised storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow  <= 16'h0000;
      active  <= 16'h0000;
      pending <= 1'b0;
    end else if (wr_valid && !pending) begin
      shadow  <= wr_data;
      pending <= 1'b1;
    end else if (frame_end && pending) begin
      active  <= shadow;
      pending <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl with CLK_DIV=4, BLANK_CYC=2.
// A frame-position model predicts every output each cycle; directed
// sequences add literal expectations at key points.
module tb_seg7_scan_ctrl;

  localparam int CLK_DIV   = 4;
  localparam int BLANK_CYC = 2;
  localparam int SLOT      = CLK_DIV + BLANK_CYC;
  localparam int FRAME     = 4 * SLOT;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        wr_valid;
  logic        wr_ready;
  logic [15:0] wr_data;
  logic        lz_en;
  logic [6:0]  seg;
  logic [3:0]  an_n;
  logic        frame_done;

  int n_tests = 0;
  int n_fail  = 0;
  logic chk_on = 1'b0;

  seg7_scan_ctrl #(.CLK_DIV(CLK_DIV), .BLANK_CYC(BLANK_CYC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_data    (wr_data),
    .lz_en      (lz_en),
    .seg        (seg),
    .an_n       (an_n),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] glyph(input logic [3:0] d);
    logic [6:0] t [10];
    t = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    return (d < 4'd10) ? t[d] : 7'h40;
  endfunction

  // Model: position within the run since reset release (the cycle before the
  // first edge is position 0, a BLANK(0) cycle), plus the write/transfer rule.
  int          m_pos;
  logic        m_pending;
  logic [15:0] m_shadow;
  logic [15:0] m_active;
  logic        m_lz;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pos     <= 0;
      m_pending <= 1'b0;
      m_shadow  <= 16'h0;
      m_active  <= 16'h0;
      m_lz      <= 1'b0;
    end else begin
      if (wr_valid && !m_pending) begin
        m_shadow  <= wr_data;
        m_pending <= 1'b1;
      end else if (m_pending && ((m_pos + 1) % FRAME == 0)) begin
        m_active  <= m_shadow;
        m_pending <= 1'b0;
      end
      m_pos <= m_pos + 1;
      m_lz  <= lz_en;
    end
  end

  int          e_q, e_slot;
  logic        e_lit;
  logic [3:0]  e_digit, e_an;
  logic [6:0]  e_seg;
  logic        e_fd;

  always @(negedge clk) begin
    if (chk_on) begin
      e_q     = m_pos % FRAME;
      e_slot  = e_q / SLOT;
      e_digit = 4'(m_active >> (4 * e_slot));
      e_lit   = (e_q % SLOT) >= BLANK_CYC;
      if (m_lz && e_slot > 0 && (m_active >> (4 * e_slot)) == 16'h0) e_lit = 1'b0;
      e_an  = e_lit ? (4'hF & ~(4'b0001 << e_slot)) : 4'hF;
      e_seg = e_lit ? glyph(e_digit) : 7'h00;
      e_fd  = (m_pos > 0) && (e_q == 0);
      check("model an_n", {28'h0, an_n}, {28'h0, e_an});
      check("model seg", {25'h0, seg}, {25'h0, e_seg});
      check("model frame_done", {31'h0, frame_done}, {31'h0, e_fd});
      check("model wr_ready", {31'h0, wr_ready}, {31'h0, !m_pending});
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Advance to the next negedge that sees frame_done; bounded.
  task automatic wait_frame(output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (frame_done !== 1'b1 && cycles < 3 * FRAME);
    if (frame_done !== 1'b1) check("frame_done wait", {31'h0, frame_done}, 32'h1);
  endtask

  task automatic write(input logic [15:0] data);
    wr_valid = 1'b1;
    wr_data  = data;
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic lit_check(input string name, input logic [3:0] ea, input logic [6:0] es);
    check({name, " an_n"}, {28'h0, an_n}, {28'h0, ea});
    check({name, " seg"}, {25'h0, seg}, {25'h0, es});
  endtask

  int n;

  initial begin
    wr_valid = 1'b0;
    wr_data  = 16'h0;
    lz_en    = 1'b0;
    #1 rst_n = 1'b0;
    #1 chk_on = 1'b1;

    // Reset state.
    @(negedge clk);
    lit_check("reset", 4'hF, 7'h00);
    check("reset frame_done", {31'h0, frame_done}, 32'h0);
    check("reset wr_ready", {31'h0, wr_ready}, 32'h1);
    @(negedge clk);
    rst_n = 1'b1;

    // Idle scan: first BLANK gap, then digit 0 lit showing 0.
    step(1);
    lit_check("idle blank", 4'hF, 7'h00);
    step(1);
    lit_check("idle d0", 4'hE, 7'h3F);
    wait_frame(n);
    wait_frame(n);
    check("frame period", n, FRAME);

    // Mid-frame write: held off the display until the boundary.
    step(9);
    write(16'h1234);
    check("write wr_ready low", {31'h0, wr_ready}, 32'h0);
    lit_check("old value d1", 4'hD, 7'h3F);
    wait_frame(n);
    check("transfer wr_ready high", {31'h0, wr_ready}, 32'h1);
    step(2);  lit_check("1234 d0", 4'hE, 7'h66);
    step(6);  lit_check("1234 d1", 4'hD, 7'h4F);
    step(6);  lit_check("1234 d2", 4'hB, 7'h5B);
    step(6);  lit_check("1234 d3", 4'h7, 7'h06);

    // Second write while pending: stalled until the transfer frees the shadow.
    write(16'h4321);
    wr_valid = 1'b1;
    wr_data  = 16'h8765;
    check("stall wr_ready", {31'h0, wr_ready}, 32'h0);
    n = 0;
    while (wr_ready !== 1'b1 && n < 3 * FRAME) begin
      @(negedge clk);
      n++;
    end
    check("stall release wr_ready", {31'h0, wr_ready}, 32'h1);
    check("stall release frame_done", {31'h0, frame_done}, 32'h1);
    @(negedge clk);
    wr_valid = 1'b0;
    check("second write accepted", {31'h0, wr_ready}, 32'h0);
    step(1);  lit_check("4321 d0", 4'hE, 7'h06);
    wait_frame(n);
    step(2);  lit_check("8765 d0", 4'hE, 7'h6D);
    step(6);  lit_check("8765 d1", 4'hD, 7'h7D);

    // Leading-zero suppression.
    lz_en = 1'b1;
    write(16'h0070);
    wait_frame(n);
    step(2);  lit_check("0070 d0", 4'hE, 7'h3F);
    step(6);  lit_check("0070 d1", 4'hD, 7'h07);
    step(6);  lit_check("0070 d2", 4'hF, 7'h00);
    step(6);  lit_check("0070 d3", 4'hF, 7'h00);

    // Invalid digit ends the zero run and shows a dash.
    write(16'h0A05);
    wait_frame(n);
    step(2);  lit_check("0A05 d0", 4'hE, 7'h6D);
    step(6);  lit_check("0A05 d1", 4'hD, 7'h3F);
    step(6);  lit_check("0A05 d2", 4'hB, 7'h40);
    step(6);  lit_check("0A05 d3", 4'hF, 7'h00);

    // Reset during SHOW(2) with a write pending.
    lz_en = 1'b0;
    wait_frame(n);
    step(1);
    write(16'h9999);
    step(12);
    lit_check("pre-reset d2", 4'hB, 7'h40);
    #2 rst_n = 1'b0;
    #1;
    lit_check("async reset", 4'hF, 7'h00);
    check("async reset wr_ready", {31'h0, wr_ready}, 32'h1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(2);
    lit_check("post-reset d0", 4'hE, 7'h3F);
    check("post-reset wr_ready", {31'h0, wr_ready}, 32'h1);
    wait_frame(n);
    step(20); lit_check("post-reset d3", 4'h7, 7'h3F);

    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
